mogu_wave_ctrl: RTL and testbench

//  Wave scheduler for the mogu (enemy) movers. Sequences one wave per rising edge of inspire:

---
 rtl/mogu_wave_ctrl_pkg.sv | 21 ++
 rtl/mogu_wave_ctrl_if.sv | 28 ++
 rtl/mogu_wave_ctrl_rr_arb4.sv | 41 ++++
 rtl/mogu_wave_ctrl.sv | 158 +++++++++++++++
 tb/tb_mogu_wave_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mogu_wave_ctrl_pkg.sv
// Shared types and constants for the mogu wave scheduler.
// Provides FSM encodings, game-state codes, enemy count and a saturating counter helper.
package mogu_wave_ctrl_pkg;

  localparam int NUM_MOGU = 4;

  localparam logic [3:0] ST_MENU  = 4'b0000;
  localparam logic [3:0] ST_PAUSE = 4'b1010;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SPAWN,
    W_ACTIVE,
    W_CLEAR
  } wave_st_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mogu_wave_ctrl_if.sv
// Game-side bundle of the mogu wave scheduler.
// master = game FSM/collision side, slave = wave scheduler.
interface mogu_wave_ctrl_if;
  import mogu_wave_ctrl_pkg::*;

  logic [3:0]          state;
  logic                inspire;
  logic [1:0]          seed;
  logic                tick;
  logic [NUM_MOGU-1:0] kill_req;
  logic [NUM_MOGU-1:0] MM;
  logic [NUM_MOGU-1:0] spawn;
  logic [NUM_MOGU-1:0] kill_ack;
  logic [7:0]          wave_num;
  logic                wave_clear;
  logic                busy;

  modport master (
    output state, inspire, seed, tick, kill_req,
    input  MM, spawn, kill_ack, wave_num, wave_clear, busy
  );

  modport slave (
    input  state, inspire, seed, tick, kill_req,
    output MM, spawn, kill_ack, wave_num, wave_clear, busy
  );

endinterface

// File: rtl/mogu_wave_ctrl_rr_arb4.sv
// 4-way round-robin arbiter: one-hot grant to first request at/after ptr.
// Ports: clk, rst, en (grant enable), req, gnt (combinational one-hot).
module mogu_wave_ctrl_rr_arb4
  import mogu_wave_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NUM_MOGU-1:0] req,
  output logic [NUM_MOGU-1:0] gnt
);

  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [1:0] cand;
  logic       found;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_MOGU; k++) begin
      cand = ptr_q + 2'(k);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        ptr_d     = cand + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mogu_wave_ctrl.sv
// Mogu wave scheduler: staggered spawns, alive mask, kill retirement, wave clear.
// Ports: clk, rst (sync, high), bus (slave: state/inspire/seed/tick/kill_req in; MM/spawn/kill_ack/wave_num/wave_clear/busy out).
module mogu_wave_ctrl
  import mogu_wave_ctrl_pkg::*;
#(
  parameter int SPAWN_GAP  = 8,
  parameter int CLEAR_HOLD = 32
) (
  input logic             clk,
  input logic             rst,
  mogu_wave_ctrl_if.slave bus
);

  localparam int GW = $clog2(SPAWN_GAP + 1);
  localparam int HW = $clog2(CLEAR_HOLD + 1);
  localparam logic [GW-1:0] GAP_LD  = GW'(SPAWN_GAP);
  localparam logic [HW-1:0] HOLD_LD = HW'(CLEAR_HOLD);

  wave_st_e            fsm_q, fsm_d;
  logic [NUM_MOGU-1:0] mm_q, mm_d;
  logic [NUM_MOGU-1:0] pend_q, pend_d;
  logic [NUM_MOGU-1:0] spawn_q, spawn_d;
  logic [NUM_MOGU-1:0] ack_q;
  logic                clr_q, clr_d;
  logic                busy_q, busy_d;
  logic [7:0]          wnum_q, wnum_d;
  logic [2:0]          idx_q, idx_d;
  logic [2:0]          n_q, n_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic                insp_q;

  logic                menu;
  logic                tick_ok;
  logic                trig;
  logic                live;
  logic [NUM_MOGU-1:0] kills;
  logic [NUM_MOGU-1:0] gnt;

  assign menu    = (bus.state == ST_MENU);
  assign tick_ok = bus.tick && (bus.state != ST_PAUSE);
  assign trig    = bus.inspire && !insp_q;
  assign live    = (fsm_q == W_SPAWN) || (fsm_q == W_ACTIVE);
  // Only live, spawned enemies can be killed; a same-cycle spawn is still dead here.
  assign kills   = live ? (bus.kill_req & mm_q) : '0;

  mogu_wave_ctrl_rr_arb4 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (!menu),
    .req (pend_q),
    .gnt (gnt)
  );

  always_comb begin
    fsm_d   = fsm_q;
    mm_d    = mm_q & ~kills;
    pend_d  = (pend_q & ~gnt) | kills;
    spawn_d = '0;
    clr_d   = 1'b0;
    wnum_d  = wnum_q;
    idx_d   = idx_q;
    n_d     = n_q;
    gap_d   = gap_q;
    hold_d  = hold_q;

    unique case (fsm_q)
      W_IDLE: begin
        if (trig && !menu) begin
          n_d    = 3'(bus.seed) + 3'd1;
          idx_d  = '0;
          gap_d  = '0;
          wnum_d = sat_inc8(wnum_q);
          fsm_d  = W_SPAWN;
        end
      end
      W_SPAWN: begin
        if (gap_q == '0) begin
          spawn_d[idx_q[1:0]] = 1'b1;
          mm_d[idx_q[1:0]]    = 1'b1;
          idx_d               = idx_q + 3'd1;
          gap_d               = GAP_LD;
          if (idx_q == n_q - 3'd1) begin
            fsm_d = W_ACTIVE;
          end
        end else if (tick_ok) begin
          gap_d = gap_q - 1'b1;
        end
      end
      W_ACTIVE: begin
        if (mm_q == '0 && pend_q == '0) begin
          fsm_d  = W_CLEAR;
          clr_d  = 1'b1;
          hold_d = HOLD_LD;
        end
      end
      W_CLEAR: begin
        if (hold_q == '0) begin
          fsm_d = W_IDLE;
        end else if (tick_ok) begin
          hold_d = hold_q - 1'b1;
        end
      end
    endcase

    // Menu aborts the wave outright; the arbiter is gated so no score leaks out.
    if (menu) begin
      fsm_d   = W_IDLE;
      mm_d    = '0;
      pend_d  = '0;
      idx_d   = '0;
      spawn_d = '0;
      clr_d   = 1'b0;
    end

    busy_d = (fsm_d != W_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= W_IDLE;
      mm_q    <= '0;
      pend_q  <= '0;
      spawn_q <= '0;
      ack_q   <= '0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      wnum_q  <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
      insp_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      mm_q    <= mm_d;
      pend_q  <= pend_d;
      spawn_q <= spawn_d;
      ack_q   <= gnt;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      wnum_q  <= wnum_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      insp_q  <= bus.inspire;
    end
  end

  assign bus.MM         = mm_q;
  assign bus.spawn      = spawn_q;
  assign bus.kill_ack   = ack_q;
  assign bus.wave_num   = wnum_q;
  assign bus.wave_clear = clr_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mogu_wave_ctrl.sv
// Testbench for mogu_wave_ctrl.
// Scoreboard queues for spawn/kill_ack pulses plus per-scenario inline checks.
module tb_mogu_wave_ctrl;
  import mogu_wave_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mogu_wave_ctrl_if bus ();

  mogu_wave_ctrl #(
    .SPAWN_GAP  (8),
    .CLEAR_HOLD (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] q_spawn[$];
  logic [3:0] q_ack[$];
  logic [3:0] exp_s;
  logic [3:0] exp_a;
  logic [3:0] m_mm;
  int m_ptr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse monitor: every spawn / kill_ack pulse must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.spawn != 4'b0) begin
        n_cmp++;
        if (q_spawn.size() == 0) begin
          n_err++;
          $display("FAIL spawn_unexpected got=%b exp=none", bus.spawn);
        end else begin
          exp_s = q_spawn.pop_front();
          if (bus.spawn !== exp_s) begin
            n_err++;
            $display("FAIL spawn_order got=%b exp=%b", bus.spawn, exp_s);
          end
        end
      end
      if (bus.kill_ack != 4'b0) begin
        n_cmp++;
        if (q_ack.size() == 0) begin
          n_err++;
          $display("FAIL ack_unexpected got=%b exp=none", bus.kill_ack);
        end else begin
          exp_a = q_ack.pop_front();
          if (bus.kill_ack !== exp_a) begin
            n_err++;
            $display("FAIL ack_order got=%b exp=%b", bus.kill_ack, exp_a);
          end
        end
      end
    end
  end

  // Reference round-robin retirement order for a kill burst.
  task automatic push_kills(input logic [3:0] kr);
    logic [3:0] p;
    int c;
    bit hit;
    p    = kr & m_mm;
    m_mm = m_mm & ~kr;
    for (int r = 0; r < 4; r++) begin
      hit = 0;
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (!hit && p[c]) begin
          hit = 1;
          q_ack.push_back(4'(1 << c));
          p[c]  = 1'b0;
          m_ptr = (c + 1) % 4;
        end
      end
    end
  endtask

  // Half-cycle steps with tick pulses until spawn (which=0) or !busy (which=1).
  task automatic ticks_until(input int which, input int limit, output int cnt);
    bit done;
    done = 0;
    cnt  = -1;
    for (int k = 1; k <= 2 * limit; k++) begin
      if (!done) begin
        bus.tick = k[0];
        step();
        if ((which == 0 && bus.spawn != 4'b0) ||
            (which == 1 && !bus.busy)) begin
          done = 1;
          cnt  = k;
        end
      end
    end
    bus.tick = 1'b0;
  endtask

  task automatic test_reset();
    bus.state = 4'b0001; bus.inspire = 0; bus.seed = 0;
    bus.tick = 0; bus.kill_req = 0;
    rst = 1; step(); step();
    if (bus.MM !== 4'b0) begin n_err++; $display("FAIL rst_mm got=%b exp=0000", bus.MM); end
    n_cmp++;
    if (bus.spawn !== 4'b0) begin n_err++; $display("FAIL rst_spawn got=%b exp=0000", bus.spawn); end
    n_cmp++;
    if (bus.kill_ack !== 4'b0) begin n_err++; $display("FAIL rst_ack got=%b exp=0000", bus.kill_ack); end
    n_cmp++;
    if (bus.wave_num !== 8'd0) begin n_err++; $display("FAIL rst_wnum got=%0d exp=0", bus.wave_num); end
    n_cmp++;
    if (bus.wave_clear !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL rst_clr_busy got=%b%b exp=00", bus.wave_clear, bus.busy);
    end
    n_cmp++;
    rst = 0; m_mm = 0; m_ptr = 0;
    step();
  endtask

  task automatic test_wave_num_sat();
    for (int i = 0; i < 260; i++) begin
      bus.inspire = 1; bus.state = 4'b0001; step();
      bus.inspire = 0; bus.state = ST_MENU; step();
    end
    bus.state = 4'b0001;
    if (bus.wave_num !== 8'd255) begin n_err++; $display("FAIL wnum_sat got=%0d exp=255", bus.wave_num); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL sat_busy got=%b exp=0", bus.busy); end
    n_cmp++;
    rst = 1; step(); rst = 0; m_mm = 0; m_ptr = 0; step();
    if (bus.wave_num !== 8'd0) begin n_err++; $display("FAIL wnum_rst got=%0d exp=0", bus.wave_num); end
    n_cmp++;
  endtask

  task automatic test_spawn();
    int c;
    bus.state = 4'b0001; bus.seed = 2'b10; bus.inspire = 1;
    q_spawn.push_back(4'b0001); q_spawn.push_back(4'b0010); q_spawn.push_back(4'b0100);
    step();
    bus.seed = 2'b00; bus.inspire = 0;
    if (bus.busy !== 1'b1 || bus.wave_num !== 8'd1) begin
      n_err++; $display("FAIL w1_start got=%b/%0d exp=1/1", bus.busy, bus.wave_num);
    end
    n_cmp++;
    if (bus.spawn !== 4'b0) begin n_err++; $display("FAIL w1_lat1 got=%b exp=0000", bus.spawn); end
    n_cmp++;
    step();
    if (bus.spawn !== 4'b0001) begin n_err++; $display("FAIL w1_lat2 got=%b exp=0001", bus.spawn); end
    n_cmp++;
    m_mm = 4'b0001;
    ticks_until(0, 20, c);
    if (c !== 16) begin n_err++; $display("FAIL w1_gap1 got=%0d exp=16", c); end
    n_cmp++;
    ticks_until(0, 20, c);
    if (c !== 16) begin n_err++; $display("FAIL w1_gap2 got=%0d exp=16", c); end
    n_cmp++;
    m_mm = 4'b0111;
    step();
    if (bus.MM !== 4'b0111 || bus.spawn !== 4'b0) begin
      n_err++; $display("FAIL w1_mm got=%b/%b exp=0111/0000", bus.MM, bus.spawn);
    end
    n_cmp++;
  endtask

  task automatic test_edge_active_and_clear();
    int c;
    bus.inspire = 1; step(); bus.inspire = 0; step();
    if (bus.wave_num !== 8'd1 || bus.MM !== 4'b0111) begin
      n_err++; $display("FAIL act_edge got=%0d/%b exp=1/0111", bus.wave_num, bus.MM);
    end
    n_cmp++;
    bus.kill_req = 4'b0100; push_kills(4'b0100); step(); bus.kill_req = 0;
    if (bus.MM !== 4'b0011) begin n_err++; $display("FAIL w1_kill2 got=%b exp=0011", bus.MM); end
    n_cmp++;
    step();
    if (bus.kill_ack !== 4'b0100) begin n_err++; $display("FAIL w1_ack2 got=%b exp=0100", bus.kill_ack); end
    n_cmp++;
    step();
    bus.kill_req = 4'b0011; push_kills(4'b0011); step(); bus.kill_req = 0;
    step(); step();
    if (bus.kill_ack !== 4'b0010 || bus.wave_clear !== 1'b0) begin
      n_err++; $display("FAIL w1_ack1 got=%b/%b exp=0010/0", bus.kill_ack, bus.wave_clear);
    end
    n_cmp++;
    step();
    if (bus.wave_clear !== 1'b1) begin n_err++; $display("FAIL w1_clear got=%b exp=1", bus.wave_clear); end
    n_cmp++;
    step();
    if (bus.wave_clear !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL w1_clr_pulse got=%b/%b exp=0/1", bus.wave_clear, bus.busy);
    end
    n_cmp++;
    bus.inspire = 1;
    ticks_until(1, 40, c);
    if (c !== 64) begin n_err++; $display("FAIL w1_hold got=%0d exp=64", c); end
    n_cmp++;
    bus.inspire = 0; step();
    if (bus.wave_num !== 8'd1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL clr_edge got=%0d/%b exp=1/0", bus.wave_num, bus.busy);
    end
    n_cmp++;
  endtask

  task automatic test_pause_and_unspawned_kill();
    int c;
    logic [3:0] seen;
    bus.seed = 2'b11; bus.inspire = 1;
    q_spawn.push_back(4'b0001); q_spawn.push_back(4'b0010);
    q_spawn.push_back(4'b0100); q_spawn.push_back(4'b1000);
    step(); bus.inspire = 0;
    if (bus.wave_num !== 8'd2) begin n_err++; $display("FAIL w2_num got=%0d exp=2", bus.wave_num); end
    n_cmp++;
    step(); m_mm = 4'b0001;
    repeat (3) begin bus.tick = 1; step(); bus.tick = 0; step(); end
    bus.state = ST_PAUSE; seen = 0;
    repeat (20) begin
      bus.tick = 1; step(); seen |= bus.spawn;
      bus.tick = 0; step(); seen |= bus.spawn;
    end
    if (seen !== 4'b0 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL pause got=%b/%b exp=0000/1", seen, bus.busy);
    end
    n_cmp++;
    bus.state = 4'b0001;
    ticks_until(0, 20, c);
    if (c !== 10) begin n_err++; $display("FAIL resume got=%0d exp=10", c); end
    n_cmp++;
    m_mm = 4'b0011;
    bus.kill_req = 4'b1000; push_kills(4'b1000); step(); bus.kill_req = 0;
    step(); step();
    if (bus.MM !== 4'b0011 || bus.kill_ack !== 4'b0) begin
      n_err++; $display("FAIL dead_kill got=%b/%b exp=0011/0000", bus.MM, bus.kill_ack);
    end
    n_cmp++;
    ticks_until(0, 20, c);
    ticks_until(0, 20, c);
    if (c !== 16 || bus.MM !== 4'b1111) begin
      n_err++; $display("FAIL w2_full got=%0d/%b exp=16/1111", c, bus.MM);
    end
    n_cmp++;
    m_mm = 4'b1111;
  endtask

  task automatic test_four_kills();
    int c;
    logic [3:0] ack_exp [4];
    ack_exp[0] = 4'b0100; ack_exp[1] = 4'b1000;
    ack_exp[2] = 4'b0001; ack_exp[3] = 4'b0010;
    step();
    bus.kill_req = 4'b1111; push_kills(4'b1111); step(); bus.kill_req = 0;
    if (bus.MM !== 4'b0 || bus.kill_ack !== 4'b0) begin
      n_err++; $display("FAIL k4_mm got=%b/%b exp=0000/0000", bus.MM, bus.kill_ack);
    end
    n_cmp++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.kill_ack !== ack_exp[i] || bus.wave_clear !== 1'b0) begin
        n_err++;
        $display("FAIL k4_ack%0d got=%b/%b exp=%b/0", i, bus.kill_ack, bus.wave_clear, ack_exp[i]);
      end
      n_cmp++;
    end
    step();
    if (bus.wave_clear !== 1'b1 || bus.kill_ack !== 4'b0) begin
      n_err++; $display("FAIL k4_clear got=%b/%b exp=1/0000", bus.wave_clear, bus.kill_ack);
    end
    n_cmp++;
    step();
    ticks_until(1, 40, c);
    if (c !== 64) begin n_err++; $display("FAIL w2_hold got=%0d exp=64", c); end
    n_cmp++;
  endtask

  task automatic test_menu();
    int c;
    bus.seed = 2'b01; bus.inspire = 1;
    q_spawn.push_back(4'b0001); q_spawn.push_back(4'b0010);
    step(); bus.inspire = 0; step();
    ticks_until(0, 20, c);
    m_mm = 4'b0011;
    step();
    bus.kill_req = 4'b0001; step(); bus.kill_req = 0; bus.state = ST_MENU;
    if (bus.MM !== 4'b0010) begin n_err++; $display("FAIL w3_kill got=%b exp=0010", bus.MM); end
    n_cmp++;
    step();
    if (bus.MM !== 4'b0 || bus.busy !== 1'b0 || bus.kill_ack !== 4'b0) begin
      n_err++; $display("FAIL menu_abort got=%b/%b/%b exp=0000/0/0000", bus.MM, bus.busy, bus.kill_ack);
    end
    n_cmp++;
    bus.inspire = 1; step(); bus.inspire = 0; step();
    if (bus.busy !== 1'b0 || bus.wave_num !== 8'd3) begin
      n_err++; $display("FAIL menu_edge got=%b/%0d exp=0/3", bus.busy, bus.wave_num);
    end
    n_cmp++;
    bus.state = 4'b0001;
    repeat (4) step();
    if (bus.kill_ack !== 4'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL menu_after got=%b/%b exp=0000/0", bus.kill_ack, bus.busy);
    end
    n_cmp++;
    m_mm = 0;
  endtask

  task automatic test_rst_mid_spawn();
    bus.seed = 2'b11; bus.inspire = 1;
    q_spawn.push_back(4'b0001);
    step(); bus.inspire = 0;
    if (bus.wave_num !== 8'd4) begin n_err++; $display("FAIL w4_num got=%0d exp=4", bus.wave_num); end
    n_cmp++;
    step();
    repeat (2) begin bus.tick = 1; step(); bus.tick = 0; step(); end
    rst = 1; step();
    if (bus.MM !== 4'b0 || bus.spawn !== 4'b0 || bus.kill_ack !== 4'b0 ||
        bus.wave_num !== 8'd0 || bus.wave_clear !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid got=%b/%b/%b/%0d/%b/%b exp=all zero",
               bus.MM, bus.spawn, bus.kill_ack, bus.wave_num, bus.wave_clear, bus.busy);
    end
    n_cmp++;
    rst = 0; m_mm = 0; m_ptr = 0;
    step(); step();
    if (bus.busy !== 1'b0 || bus.spawn !== 4'b0) begin
      n_err++; $display("FAIL post_rst got=%b/%b exp=0/0000", bus.busy, bus.spawn);
    end
    n_cmp++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wave_num_sat();
    test_spawn();
    test_edge_active_and_clear();
    test_pause_and_unspawned_kill();
    test_four_kills();
    test_menu();
    test_rst_mid_spawn();
    repeat (3) step();
    if (q_spawn.size() != 0) begin
      n_err++; $display("FAIL spawn_left got=%0d exp=0", q_spawn.size());
    end
    n_cmp++;
    if (q_ack.size() != 0) begin
      n_err++; $display("FAIL ack_left got=%0d exp=0", q_ack.size());
    end
    n_cmp++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
